bsg_arb_fixed_mux_buf: RTL and testbench

Downstream data stage for the fixed-priority arbiter. It arbitrates among `inputs_p` valid/data request channels, steers the winning beat into a registered 2-entry output buffer, and presents the beat with its source index on a valid/ready output port. The buffer's free space drives the arbiter's ready. There is no combinational path from `ready_i` to `yumi_o`.

---
 rtl/bsg_arb_mux_buf_pkg.sv | 13 +
 rtl/bsg_arb_fixed.sv | 36 +++
 rtl/bsg_arb_mux_buf_two_entry.sv | 74 +++++++
 rtl/bsg_arb_fixed_mux_buf.sv | 120 ++++++++++++
 tb/tb_bsg_arb_fixed_mux_buf.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bsg_arb_mux_buf_pkg.sv
// Shared types and constants for the fixed-priority arbiter mux/buffer stage.
// Lock state enum, buffer depth, and the id-width helper.
package bsg_arb_mux_buf_pkg;

    typedef enum logic {StIdle, StLocked} lock_state_e;

    localparam int unsigned BufDepth = 2;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bsg_arb_fixed.sv
// Combinational fixed-priority arbiter: one-hot grant to the highest (or lowest)
// index request, all grants gated by ready_i.
module bsg_arb_fixed #(
    parameter int unsigned inputs_p   = 32,
    parameter int unsigned lo_to_hi_p = 0
) (
    input  logic                ready_i,
    input  logic [inputs_p-1:0] reqs_i,
    output logic [inputs_p-1:0] grants_o
);

    logic found;

    always_comb begin
        grants_o = '0;
        found    = 1'b0;
        if (ready_i) begin
            if (lo_to_hi_p != 0) begin
                for (int i = 0; i < int'(inputs_p); i++) begin
                    if (!found && reqs_i[i]) begin
                        grants_o[i] = 1'b1;
                        found       = 1'b1;
                    end
                end
            end else begin
                for (int i = int'(inputs_p) - 1; i >= 0; i--) begin
                    if (!found && reqs_i[i]) begin
                        grants_o[i] = 1'b1;
                        found       = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/bsg_arb_mux_buf_two_entry.sv
// Two-entry FIFO holding {data, last, id}; head fields are read straight from
// storage, so they show stale contents when empty.
module bsg_arb_mux_buf_two_entry
    import bsg_arb_mux_buf_pkg::*;
#(
    parameter int unsigned width_p    = 32,
    parameter int unsigned id_width_p = 5
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  enq_i,
    input  logic [width_p-1:0]    enq_data_i,
    input  logic                  enq_last_i,
    input  logic [id_width_p-1:0] enq_id_i,
    input  logic                  deq_i,
    output logic                  space_o,
    output logic                  v_o,
    output logic [width_p-1:0]    data_o,
    output logic                  last_o,
    output logic [id_width_p-1:0] id_o
);

    typedef struct packed {
        logic [width_p-1:0]    data;
        logic                  last;
        logic [id_width_p-1:0] id;
    } entry_t;

    entry_t     mem_q [BufDepth];
    entry_t     mem_d [BufDepth];
    logic [1:0] count_q, count_d;
    logic       rptr_q, rptr_d;
    logic       wptr_q, wptr_d;

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        if (enq_i) begin
            mem_d[wptr_q] = '{data: enq_data_i, last: enq_last_i, id: enq_id_i};
            wptr_d        = ~wptr_q;
        end
        if (deq_i) begin
            rptr_d = ~rptr_q;
        end
        unique case ({enq_i, deq_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mem_q   <= '{default: '0};
            count_q <= '0;
            rptr_q  <= 1'b0;
            wptr_q  <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
        end
    end

    assign space_o = (count_q < 2'(BufDepth));
    assign v_o     = (count_q != 2'd0);
    assign data_o  = mem_q[rptr_q].data;
    assign last_o  = mem_q[rptr_q].last;
    assign id_o    = mem_q[rptr_q].id;

endmodule

// File: rtl/bsg_arb_fixed_mux_buf.sv
// Arbitrate request channels into a registered 2-entry output buffer.
// Define BSG_ARB_MUX_BUF_LOCK_EN to hold the grant on one channel until last_i.
module bsg_arb_fixed_mux_buf
    import bsg_arb_mux_buf_pkg::*;
#(
    parameter int unsigned inputs_p   = 32,
    parameter int unsigned width_p    = 32,
    parameter int unsigned lo_to_hi_p = 0,
    localparam int unsigned IdW       = id_width(inputs_p)
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [inputs_p-1:0]         v_i,
    input  logic [inputs_p*width_p-1:0] data_i,
    input  logic [inputs_p-1:0]         last_i,
    output logic [inputs_p-1:0]         yumi_o,
    output logic                        v_o,
    output logic [width_p-1:0]          data_o,
    output logic                        last_o,
    output logic [IdW-1:0]              id_o,
    input  logic                        ready_i
);

    logic                en_q, en_d;
    logic                buf_space, space;
    logic [inputs_p-1:0] cand, grant;
    logic [IdW-1:0]      win_id;
    logic [width_p-1:0]  win_data;
    logic                win_last;
    logic                enq, deq;

    assign en_d  = 1'b1;
    assign space = en_q & buf_space;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) en_q <= 1'b0;
        else            en_q <= en_d;
    end

`ifdef BSG_ARB_MUX_BUF_LOCK_EN
    lock_state_e    state_q, state_d;
    logic [IdW-1:0] lock_id_q, lock_id_d;

    always_comb begin
        cand      = v_i;
        state_d   = state_q;
        lock_id_d = lock_id_q;
        if (state_q == StLocked) begin
            cand            = '0;
            cand[lock_id_q] = v_i[lock_id_q];
        end
        if (enq) begin
            if (state_q == StIdle && !win_last) begin
                state_d   = StLocked;
                lock_id_d = win_id;
            end else if (state_q == StLocked && win_last) begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= StIdle;
            lock_id_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
        end
    end
`else
    assign cand = v_i;
`endif

    bsg_arb_fixed #(
        .inputs_p   (inputs_p),
        .lo_to_hi_p (lo_to_hi_p)
    ) u_arb (
        .ready_i  (space),
        .reqs_i   (cand),
        .grants_o (grant)
    );

    // Grant is one-hot, so an OR-style scan yields the winner's fields.
    always_comb begin
        win_id   = '0;
        win_data = '0;
        win_last = 1'b0;
        for (int unsigned i = 0; i < inputs_p; i++) begin
            if (grant[i]) begin
                win_id   = IdW'(i);
                win_data = data_i[i*width_p +: width_p];
                win_last = last_i[i];
            end
        end
    end

    assign enq    = |grant;
    assign deq    = v_o & ready_i;
    assign yumi_o = grant;

    bsg_arb_mux_buf_two_entry #(
        .width_p    (width_p),
        .id_width_p (IdW)
    ) u_buf (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .enq_i      (enq),
        .enq_data_i (win_data),
        .enq_last_i (win_last),
        .enq_id_i   (win_id),
        .deq_i      (deq),
        .space_o    (buf_space),
        .v_o        (v_o),
        .data_o     (data_o),
        .last_o     (last_o),
        .id_o       (id_o)
    );

endmodule

// File: tb/tb_bsg_arb_fixed_mux_buf.sv
// Scoreboard bench for bsg_arb_fixed_mux_buf: directed stimulus pushes expected
// beats, a negedge monitor pops and compares every accepted output beat.
module tb_bsg_arb_fixed_mux_buf;

    localparam int unsigned N = 32;
    localparam int unsigned W = 32;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   v_i;
    logic [N*W-1:0] data_i;
    logic [N-1:0]   last_i;
    logic [N-1:0]   yumi_o;
    logic           v_o;
    logic [W-1:0]   data_o;
    logic           last_o;
    logic [4:0]     id_o;
    logic           ready_i;

    typedef struct packed {
        logic [4:0]   id;
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    always #5 clk = ~clk;

    bsg_arb_fixed_mux_buf #(
        .inputs_p   (N),
        .width_p    (W),
        .lo_to_hi_p (0)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .v_i       (v_i),
        .data_i    (data_i),
        .last_i    (last_i),
        .yumi_o    (yumi_o),
        .v_o       (v_o),
        .data_o    (data_o),
        .last_o    (last_o),
        .id_o      (id_o),
        .ready_i   (ready_i)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input logic [W-1:0] d, input logic l);
        exp_q.push_back('{id: 5'(id), data: d, last: l});
    endtask

    task automatic set_data(input int ch, input logic [W-1:0] d);
        data_i[ch*W +: W] = d;
    endtask

    // Monitor: every accepted beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset_n && v_o && ready_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {27'd0, id_o, data_o}, 64'hDEAD);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check("beat_id",   64'(id_o),   64'(e.id));
                check("beat_data", 64'(data_o), 64'(e.data));
                check("beat_last", 64'(last_o), 64'(e.last));
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        ready_i = 1'b0;
        v_i     = '1;
        last_i  = '1;
        for (int k = 0; k < int'(N); k++) set_data(k, 32'hA000_0000 | W'(k));

        // Reset release
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_yumi", 64'(yumi_o), 64'd0);
        check("rst_v",    64'(v_o),    64'd0);
        check("rst_data", 64'(data_o), 64'd0);
        check("rst_last", 64'(last_o), 64'd0);
        check("rst_id",   64'(id_o),   64'd0);
        #1 reset_n = 1'b1;
        #1 check("pre_en_yumi", 64'(yumi_o), 64'd0);
        step();
        @(negedge clk);
        check("first_grant", 64'(yumi_o), 64'h8000_0000);
        push(31, 32'hA000_001F, 1'b1);
        step();
        v_i = '0;
        @(negedge clk);
        check("first_v",  64'(v_o),  64'd1);
        check("first_id", 64'(id_o), 64'd31);
        step();
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        @(negedge clk);
        check("empty_after_first", 64'(v_o), 64'd0);

        // Priority and backpressure
        step();
        v_i = 32'h0000_0005;
        @(negedge clk);
        check("bp_grant0", 64'(yumi_o), 64'h4);
        push(2, 32'hA000_0002, 1'b1);
        step();
        @(negedge clk);
        check("bp_grant1", 64'(yumi_o), 64'h4);
        push(2, 32'hA000_0002, 1'b1);
        step();
        @(negedge clk);
        check("bp_full_yumi", 64'(yumi_o), 64'd0);
        check("bp_full_v",    64'(v_o),    64'd1);
        check("bp_full_id",   64'(id_o),   64'd2);
        step();
        ready_i = 1'b1;
        @(negedge clk);
        check("bp_deq_cycle_yumi", 64'(yumi_o), 64'd0);
        step();
        @(negedge clk);
        check("bp_regrant", 64'(yumi_o), 64'h4);
        push(2, 32'hA000_0002, 1'b1);
        step();
        v_i = '0;
        repeat (2) step();
        @(negedge clk);
        check("bp_drained", 64'(v_o), 64'd0);

        // Streaming
        for (int i = 0; i < 100; i++) begin
            step();
            v_i = 32'h0000_0080;
            set_data(7, W'(i));
            @(negedge clk);
            check("stream_yumi", 64'(yumi_o), 64'h80);
            push(7, W'(i), 1'b1);
        end
        step();
        v_i = '0;
        repeat (3) step();
        @(negedge clk);
        check("stream_drained", 64'(exp_q.size()), 64'd0);

        // Locking
        last_i = '0;
        last_i[30] = 1'b1;
        step();
        v_i = 32'h0000_0008;
        set_data(3, 32'd300);
        set_data(30, 32'd3000);
        @(negedge clk);
        check("lock_c0", 64'(yumi_o), 64'h8);
        push(3, 32'd300, 1'b0);
        step();
        v_i = 32'h4000_0008;
        set_data(3, 32'd301);
`ifdef BSG_ARB_MUX_BUF_LOCK_EN
        @(negedge clk);
        check("lock_c1", 64'(yumi_o), 64'h8);
        push(3, 32'd301, 1'b0);
        step();
        set_data(3, 32'd302);
        last_i[3] = 1'b1;
        @(negedge clk);
        check("lock_c2", 64'(yumi_o), 64'h8);
        push(3, 32'd302, 1'b1);
        step();
        v_i = 32'h4000_0000;
        @(negedge clk);
        check("lock_c3", 64'(yumi_o), 64'h4000_0000);
        push(30, 32'd3000, 1'b1);
`else
        @(negedge clk);
        check("nolock_c1", 64'(yumi_o), 64'h4000_0000);
        push(30, 32'd3000, 1'b1);
        step();
        v_i = 32'h0000_0008;
        @(negedge clk);
        check("nolock_c2", 64'(yumi_o), 64'h8);
        push(3, 32'd301, 1'b0);
`endif
        step();
        v_i    = '0;
        last_i = '1;
        repeat (3) step();
        @(negedge clk);
        check("lock_drained", 64'(exp_q.size()), 64'd0);

        // Mid-operation reset with two beats buffered
        step();
        ready_i = 1'b0;
        v_i     = 32'h0000_0020;
        @(negedge clk);
        check("mr_grant0", 64'(yumi_o), 64'h20);
        step();
        @(negedge clk);
        check("mr_grant1", 64'(yumi_o), 64'h20);
        step();
        v_i = '1;
        @(negedge clk);
        check("mr_full_yumi", 64'(yumi_o), 64'd0);
        check("mr_full_v",    64'(v_o),    64'd1);
        #1 reset_n = 1'b0;
        #1;
        check("mr_v",     64'(v_o),               64'd0);
        check("mr_count", 64'(dut.u_buf.count_q), 64'd0);
        check("mr_yumi",  64'(yumi_o),            64'd0);
        step();
        @(negedge clk);
        check("mr_yumi_in_reset", 64'(yumi_o), 64'd0);
        #1;
        v_i     = '0;
        reset_n = 1'b1;
        ready_i = 1'b1;
        repeat (4) step();
        @(negedge clk);
        check("mr_no_stale", 64'(v_o), 64'd0);

        repeat (2) step();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
